// File: rtl/fir_filter_top.sv
// rtl/fir_filter_top.sv - 16-tap symmetric low-pass FIR, 3-stage pipeline, round-half-up and saturate
module fir_filter_top #(
  parameter int D_W = 12
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [D_W-1:0] fir_in,
  output logic [D_W-1:0] fir_out
);

  localparam int NTAP = 16;
  localparam int C_W  = 12;
  localparam int P_W  = D_W + C_W;
  localparam int A_W  = D_W + 16;
  localparam int FRAC = 11;

  // Q1.11 taps; they sum to 2048 so the DC gain is exactly one
  localparam logic signed [C_W-1:0] H [NTAP] = '{
    -12'sd8,  -12'sd12, 12'sd0,   12'sd44,
    12'sd120, 12'sd216, 12'sd300, 12'sd364,
    12'sd364, 12'sd300, 12'sd216, 12'sd120,
    12'sd44,  12'sd0,   -12'sd12, -12'sd8
  };

  logic signed [D_W-1:0] x_q   [NTAP];
  logic signed [P_W-1:0] p_d   [NTAP];
  logic signed [P_W-1:0] p_q   [NTAP];
  logic signed [A_W-1:0] acc_d;
  logic signed [A_W-1:0] acc_q;
  logic signed [A_W-1:0] rnd;
  logic signed [A_W-1:0] shf;
  logic        [D_W-1:0] out_d;
  logic        [D_W-1:0] out_q;

  // Delay line: newest sample enters x[0], older samples move toward x[15]
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAP; k++) x_q[k] <= '0;
    end else begin
      x_q[0] <= $signed(fir_in);
      for (int k = 1; k < NTAP; k++) x_q[k] <= x_q[k-1];
    end
  end

  // Full-precision tap products; operands are sign-extended before multiplying
  always_comb begin
    for (int k = 0; k < NTAP; k++) begin
      p_d[k] = P_W'(x_q[k]) * P_W'(H[k]);
    end
  end

  // Product stage register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAP; k++) p_q[k] <= '0;
    end else begin
      for (int k = 0; k < NTAP; k++) p_q[k] <= p_d[k];
    end
  end

  // Sum of all products; the accumulator width has headroom for full-scale input
  always_comb begin
    acc_d = '0;
    for (int k = 0; k < NTAP; k++) begin
      acc_d = acc_d + A_W'(p_q[k]);
    end
  end

  // Accumulator stage register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Round half toward +inf: add half an LSB of the output, then floor-shift
  assign rnd = acc_q + A_W'(1024);
  assign shf = rnd >>> FRAC;

  // Clamp to the output range: in range only when all bits above the output sign agree with it
  always_comb begin
    out_d = shf[D_W-1:0];
    if (!((&shf[A_W-1:D_W-1]) || !(|shf[A_W-1:D_W-1]))) begin
      if (shf[A_W-1]) begin
        out_d = {1'b1, {(D_W-1){1'b0}}};
      end else begin
        out_d = {1'b0, {(D_W-1){1'b1}}};
      end
    end
  end

  // Output stage register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign fir_out = out_q;

endmodule

// File: tb/tb_fir_filter_top.sv
// tb/tb_fir_filter_top.sv - directed bench for fir_filter_top with hand values and a reference formula
module tb_fir_filter_top;

  localparam int D_W = 12;

  logic           clock = 1'b0;
  logic           reset;
  logic [D_W-1:0] fir_in;
  logic [D_W-1:0] fir_out;

  int n_cmp = 0;
  int n_bad = 0;

  int H   [16] = '{-8, -12, 0, 44, 120, 216, 300, 364, 364, 300, 216, 120, 44, 0, -12, -8};
  int IMP [16] = '{-8, -12, 0, 44, 120, 216, 300, 364, 364, 300, 216, 120, 44, 0, -12, -8};
  int SAT [16] = '{-2048, -2048, 2047, 2047, 2047, 2047, 2047, 2047,
                   2047, 2047, 2047, 2047, 2047, 2047, -2048, -2048};
  int hist [16];
  int pipe [3];
  int exp_out;

  always #5 clock = ~clock;

  fir_filter_top #(.D_W(D_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .fir_in  (fir_in),
    .fir_out (fir_out)
  );

  task automatic check(input string tag, input int got, input int expv);
    n_cmp++;
    assert (got === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic int model();
    longint acc;
    acc = 0;
    for (int k = 0; k < 16; k++) acc += longint'(hist[k]) * longint'(H[k]);
    acc = (acc + 1024) >>> 11;
    if (acc > 2047) acc = 2047;
    if (acc < -2048) acc = -2048;
    return int'(acc);
  endfunction

  task automatic flush();
    for (int k = 0; k < 16; k++) hist[k] = 0;
    for (int k = 0; k < 3; k++) pipe[k] = 0;
    exp_out = 0;
  endtask

  // Drive one sample, advance the reference by one edge, compare at the following negedge
  task automatic step(input int v);
    fir_in = v[D_W-1:0];
    @(posedge clock);
    exp_out = pipe[2];
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
    pipe[0] = model();
    @(negedge clock);
    check("model", $signed(fir_out), exp_out);
  endtask

  initial begin
    int v;
    flush();
    fir_in = '0;
    reset  = 1'b1;
    #3 reset = 1'b0;
    #1 check("reset_async", $signed(fir_out), 0);

    // Reset held for 10 cycles with random input
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      fir_in = D_W'($urandom);
      check("reset_hold", $signed(fir_out), 0);
    end
    @(negedge clock);
    fir_in = '0;
    reset  = 1'b1;

    // Idle after release
    for (int i = 0; i < 100; i++) begin
      step(0);
      check("idle_zero", $signed(fir_out), 0);
    end

    // Impulse
    step(2047);
    check("imp_lat0", $signed(fir_out), 0);
    step(0);
    check("imp_lat1", $signed(fir_out), 0);
    step(0);
    check("imp_lat2", $signed(fir_out), 0);
    for (int i = 0; i < 16; i++) begin
      step(0);
      check($sformatf("impulse[%0d]", i), $signed(fir_out), IMP[i]);
    end
    for (int i = 0; i < 4; i++) begin
      step(0);
      check("imp_tail", $signed(fir_out), 0);
    end

    // DC positive and negative full scale
    for (int i = 1; i <= 30; i++) begin
      step(2047);
      if (i >= 19) check("dc_pos", $signed(fir_out), 2047);
    end
    for (int i = 1; i <= 30; i++) begin
      step(-2048);
      if (i >= 19) check("dc_neg", $signed(fir_out), -2048);
    end

    // Sign-matched full-scale pattern: aligned outputs exceed range and must clamp high
    for (int i = 1; i <= 48; i++) begin
      step(SAT[(i-1) % 16]);
      if (i >= 19 && ((i - 3) % 16) == 0) check("sat_clamp", $signed(fir_out), 2047);
    end

    // Sine stream with a mid-stream reset
    for (int i = 0; i < 96; i++) begin
      v = $rtoi(2000.0 * $sin(6.283185307 * i / 32.0));
      step(v);
      if (i == 48) begin
        #2 reset = 1'b0;
        #1 check("reset_mid_async", $signed(fir_out), 0);
        flush();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("reset_mid_hold", $signed(fir_out), 0);
        reset = 1'b1;
      end
    end

    // Drain to zero
    for (int i = 0; i < 20; i++) step(0);
    check("drain_zero", $signed(fir_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
